axi5_slave_rd_responder: RTL and testbench



---
 rtl/axi5_pkg.sv | 24 ++
 rtl/axi5_slave_rd_responder_if.sv | 89 ++++++++
 rtl/axi5_rd_addr_gen.sv | 39 +++
 rtl/axi5_slave_rd_responder.sv | 190 +++++++++++++++++++
 tb/tb_axi5_slave_rd_responder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi5_pkg.sv
// Shared AXI5 encodings and the read-responder FSM state type.
package axi5_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_ERR  = 3'd4
  } rd_state_e;

endpackage

// File: rtl/axi5_slave_rd_responder_if.sv
// AXI5 AR/R channels plus the backend request/response port of the read responder.
interface axi5_slave_rd_responder_if #(
  parameter int AXI_ID_WIDTH       = 8,
  parameter int AXI_ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH     = 32,
  parameter int AXI_USER_WIDTH     = 1,
  parameter int AXI_NSAID_WIDTH    = 4,
  parameter int AXI_MECID_WIDTH    = 16,
  parameter int AXI_MPAM_WIDTH     = 11,
  parameter int AXI_TAG_WIDTH      = 4,
  parameter int AXI_TAGOP_WIDTH    = 2,
  parameter int AXI_CHUNKNUM_WIDTH = 4
);
  localparam int CHUNK_STRB_WIDTH = (AXI_DATA_WIDTH >= 128) ? AXI_DATA_WIDTH / 128 : 1;
  localparam int TW               = AXI_TAG_WIDTH * CHUNK_STRB_WIDTH;

  logic [AXI_ID_WIDTH-1:0]       s_axi_arid;
  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr;
  logic [7:0]                    s_axi_arlen;
  logic [2:0]                    s_axi_arsize;
  logic [1:0]                    s_axi_arburst;
  logic [2:0]                    s_axi_arprot;
  logic                          s_axi_arlock;
  logic [3:0]                    s_axi_arcache;
  logic [3:0]                    s_axi_arqos;
  logic [AXI_USER_WIDTH-1:0]     s_axi_aruser;
  logic [AXI_MPAM_WIDTH-1:0]     s_axi_armpam;
  logic                          s_axi_arunique;
  logic                          s_axi_archunken;
  logic [AXI_TAGOP_WIDTH-1:0]    s_axi_artagop;
  logic [AXI_NSAID_WIDTH-1:0]    s_axi_arnsaid;
  logic [AXI_MECID_WIDTH-1:0]    s_axi_armecid;
  logic                          s_axi_artrace;
  logic                          s_axi_arvalid;
  logic                          s_axi_arready;

  logic [AXI_ID_WIDTH-1:0]       s_axi_rid;
  logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata;
  logic [1:0]                    s_axi_rresp;
  logic                          s_axi_rlast;
  logic [AXI_USER_WIDTH-1:0]     s_axi_ruser;
  logic                          s_axi_rtrace;
  logic                          s_axi_rpoison;
  logic [TW-1:0]                 s_axi_rtag;
  logic                          s_axi_rtagmatch;
  logic                          s_axi_rchunkv;
  logic [AXI_CHUNKNUM_WIDTH-1:0] s_axi_rchunknum;
  logic [CHUNK_STRB_WIDTH-1:0]   s_axi_rchunkstrb;
  logic                          s_axi_rvalid;
  logic                          s_axi_rready;

  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic [AXI_ADDR_WIDTH-1:0]     mem_req_addr;
  logic [2:0]                    mem_req_prot;
  logic [AXI_NSAID_WIDTH-1:0]    mem_req_nsaid;
  logic [AXI_MECID_WIDTH-1:0]    mem_req_mecid;
  logic                          mem_rsp_valid;
  logic                          mem_rsp_ready;
  logic [AXI_DATA_WIDTH-1:0]     mem_rsp_data;
  logic                          mem_rsp_err;
  logic                          mem_rsp_poison;
  logic [TW-1:0]                 mem_rsp_tag;

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arprot,
           s_axi_arlock, s_axi_arcache, s_axi_arqos, s_axi_aruser, s_axi_armpam,
           s_axi_arunique, s_axi_archunken, s_axi_artagop, s_axi_arnsaid, s_axi_armecid,
           s_axi_artrace, s_axi_arvalid, s_axi_rready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err, mem_rsp_poison, mem_rsp_tag,
    output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser,
           s_axi_rtrace, s_axi_rpoison, s_axi_rtag, s_axi_rtagmatch, s_axi_rchunkv,
           s_axi_rchunknum, s_axi_rchunkstrb, s_axi_rvalid,
           mem_req_valid, mem_req_addr, mem_req_prot, mem_req_nsaid, mem_req_mecid, mem_rsp_ready
  );

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arprot,
           s_axi_arlock, s_axi_arcache, s_axi_arqos, s_axi_aruser, s_axi_armpam,
           s_axi_arunique, s_axi_archunken, s_axi_artagop, s_axi_arnsaid, s_axi_armecid,
           s_axi_artrace, s_axi_arvalid, s_axi_rready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err, mem_rsp_poison, mem_rsp_tag,
    input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser,
           s_axi_rtrace, s_axi_rpoison, s_axi_rtag, s_axi_rtagmatch, s_axi_rchunkv,
           s_axi_rchunknum, s_axi_rchunkstrb, s_axi_rvalid,
           mem_req_valid, mem_req_addr, mem_req_prot, mem_req_nsaid, mem_req_mecid, mem_rsp_ready
  );

endinterface

// File: rtl/axi5_rd_addr_gen.sv
// Combinational AXI next-beat address for FIXED / INCR / WRAP bursts.
module axi5_rd_addr_gen
  import axi5_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [2:0]                size,
  input  burst_e                    burst,
  input  logic [7:0]                len,
  output logic [AXI_ADDR_WIDTH-1:0] next_addr
);
  localparam int AW = AXI_ADDR_WIDTH;

  logic [AW-1:0] step;
  logic [AW-1:0] aligned;
  logic [AW-1:0] stepped;
  logic [AW-1:0] wrap_bytes;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] wrap_base;

  // Align to the transfer size, step one beat, and fold back into the wrap container.
  always_comb begin
    step       = AW'(1) << size;
    aligned    = addr & ~(step - AW'(1));
    stepped    = aligned + step;
    wrap_bytes = (AW'(len) + AW'(1)) << size;
    wrap_mask  = ~(wrap_bytes - AW'(1));
    wrap_base  = addr & wrap_mask;
    next_addr  = stepped;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = stepped;
      BURST_WRAP:  next_addr = ((stepped & wrap_mask) != wrap_base) ? wrap_base : stepped;
      default:     next_addr = stepped;
    endcase
  end

endmodule

// File: rtl/axi5_slave_rd_responder.sv
// AXI5 read responder: one AR at a time, one backend read per beat, AXI5 R sideband.
module axi5_slave_rd_responder
  import axi5_pkg::*;
#(
  parameter int          AXI_ID_WIDTH       = 8,
  parameter int          AXI_ADDR_WIDTH     = 32,
  parameter int          AXI_DATA_WIDTH     = 32,
  parameter int          AXI_USER_WIDTH     = 1,
  parameter int          AXI_NSAID_WIDTH    = 4,
  parameter int          AXI_MECID_WIDTH    = 16,
  parameter int          AXI_MPAM_WIDTH     = 11,
  parameter int          AXI_TAG_WIDTH      = 4,
  parameter int          AXI_TAGOP_WIDTH    = 2,
  parameter int          AXI_CHUNKNUM_WIDTH = 4,
  parameter logic [63:0] BASE_ADDR          = 64'h0,
  parameter logic [63:0] SIZE_BYTES         = 64'h1000
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axi5_slave_rd_responder_if.slave  bus,
  output logic                      busy
);
  localparam int         AW               = AXI_ADDR_WIDTH;
  localparam int         DW               = AXI_DATA_WIDTH;
  localparam int         CHUNK_STRB_WIDTH = (DW >= 128) ? DW / 128 : 1;
  localparam int         TW               = AXI_TAG_WIDTH * CHUNK_STRB_WIDTH;
  localparam logic [2:0] SIZE_MAX         = 3'($clog2(DW / 8));

  rd_state_e                  state_q, state_d;
  logic                       rst_done_q;
  logic [AW-1:0]              addr_q;
  logic [7:0]                 len_q;
  logic [2:0]                 size_q;
  burst_e                     burst_q;
  logic [2:0]                 prot_q;
  logic [AXI_NSAID_WIDTH-1:0] nsaid_q;
  logic [AXI_MECID_WIDTH-1:0] mecid_q;
  logic [AXI_ID_WIDTH-1:0]    id_q;
  logic                       trace_q;
  logic [7:0]                 beat_cnt_q;
  logic [DW-1:0]              data_q;
  logic [1:0]                 resp_q;
  logic                       poison_q;
  logic [TW-1:0]              tag_q;

  logic          arready, rvalid, rlast, req_valid, rsp_ready;
  logic          ar_hs, r_hs;
  logic          decerr, slverr;
  logic [1:0]    ar_resp;
  logic [64:0]   ar_addr_ext, win_lo, win_hi;
  logic [AW-1:0] next_addr;
  burst_e        ar_burst;

  axi5_rd_addr_gen #(.AXI_ADDR_WIDTH(AW)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .len       (len_q),
    .next_addr (next_addr)
  );

  // Classify the incoming AR: window decode first, then size/burst/wrap-length legality.
  always_comb begin
    ar_burst    = burst_e'(bus.s_axi_arburst);
    ar_addr_ext = 65'(bus.s_axi_araddr);
    win_lo      = 65'(BASE_ADDR);
    win_hi      = 65'(BASE_ADDR) + 65'(SIZE_BYTES);
    decerr      = (ar_addr_ext < win_lo) || (ar_addr_ext >= win_hi);
    slverr      = (bus.s_axi_arsize > SIZE_MAX) || (ar_burst == BURST_RSVD) ||
                  ((ar_burst == BURST_WRAP) && !(bus.s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    ar_resp     = decerr ? RESP_DECERR : (slverr ? RESP_SLVERR : RESP_OKAY);
  end

  // State register; rst_done_q keeps arready low for the whole reset window.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    arready   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rvalid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        arready = rst_done_q;
        if (rst_done_q && bus.s_axi_arvalid) state_d = (decerr || slverr) ? ST_ERR : ST_ADDR;
      end
      ST_ADDR: begin
        req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        rsp_ready = 1'b1;
        if (bus.mem_rsp_valid) state_d = ST_RESP;
      end
      ST_RESP: begin
        rvalid = 1'b1;
        if (bus.s_axi_rready) state_d = (beat_cnt_q == 8'd0) ? ST_IDLE : ST_ADDR;
      end
      ST_ERR: begin
        rvalid = 1'b1;
        if (bus.s_axi_rready && (beat_cnt_q == 8'd0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ar_hs = arready && bus.s_axi_arvalid;
  assign r_hs  = rvalid && bus.s_axi_rready;
  assign rlast = rvalid && (beat_cnt_q == 8'd0);

  // Burst context capture, per-beat response registers and address walk.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= BURST_FIXED;
      prot_q     <= '0;
      nsaid_q    <= '0;
      mecid_q    <= '0;
      id_q       <= '0;
      trace_q    <= 1'b0;
      beat_cnt_q <= '0;
      data_q     <= '0;
      resp_q     <= RESP_OKAY;
      poison_q   <= 1'b0;
      tag_q      <= '0;
    end else begin
      if (ar_hs) begin
        addr_q     <= bus.s_axi_araddr;
        len_q      <= bus.s_axi_arlen;
        size_q     <= bus.s_axi_arsize;
        burst_q    <= ar_burst;
        prot_q     <= bus.s_axi_arprot;
        nsaid_q    <= bus.s_axi_arnsaid;
        mecid_q    <= bus.s_axi_armecid;
        id_q       <= bus.s_axi_arid;
        trace_q    <= bus.s_axi_artrace;
        beat_cnt_q <= bus.s_axi_arlen;
        data_q     <= '0;
        resp_q     <= ar_resp;
        poison_q   <= 1'b0;
        tag_q      <= '0;
      end
      if ((state_q == ST_DATA) && bus.mem_rsp_valid) begin
        data_q   <= bus.mem_rsp_data;
        resp_q   <= bus.mem_rsp_err ? RESP_SLVERR : RESP_OKAY;
        poison_q <= bus.mem_rsp_poison;
        tag_q    <= bus.mem_rsp_tag;
      end
      if (r_hs && (beat_cnt_q != 8'd0)) begin
        beat_cnt_q <= beat_cnt_q - 8'd1;
        if (state_q == ST_RESP) addr_q <= next_addr;
      end
    end
  end

  assign busy                 = (state_q != ST_IDLE);
  assign bus.s_axi_arready    = arready;
  assign bus.s_axi_rvalid     = rvalid;
  assign bus.s_axi_rid        = id_q;
  assign bus.s_axi_rdata      = data_q;
  assign bus.s_axi_rresp      = resp_q;
  assign bus.s_axi_rlast      = rlast;
  assign bus.s_axi_ruser      = '0;
  assign bus.s_axi_rtrace     = trace_q;
  assign bus.s_axi_rpoison    = poison_q;
  assign bus.s_axi_rtag       = tag_q;
  assign bus.s_axi_rtagmatch  = 1'b0;
  assign bus.s_axi_rchunkv    = 1'b0;
  assign bus.s_axi_rchunknum  = '0;
  assign bus.s_axi_rchunkstrb = '0;
  assign bus.mem_req_valid    = req_valid;
  assign bus.mem_req_addr     = addr_q;
  assign bus.mem_req_prot     = prot_q;
  assign bus.mem_req_nsaid    = nsaid_q;
  assign bus.mem_req_mecid    = mecid_q;
  assign bus.mem_rsp_ready    = rsp_ready;

endmodule

// File: tb/tb_axi5_slave_rd_responder.sv
// Directed bench for axi5_slave_rd_responder with a zero-wait backend model.
module tb_axi5_slave_rd_responder;
  logic aclk = 1'b0;
  logic aresetn;
  logic busy;

  always #5 aclk = ~aclk;

  axi5_slave_rd_responder_if ifc ();

  axi5_slave_rd_responder dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (ifc),
    .busy    (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Backend: always ready, answers the latest request address with a recognisable pattern.
  logic        log_clr;
  int          req_cnt;
  int          inj_idx;
  logic [31:0] req_addr_q;
  logic [31:0] req_log [16];

  always @(posedge aclk) begin
    if (log_clr) req_cnt <= 0;
    else if (ifc.mem_req_valid && ifc.mem_req_ready) begin
      req_log[req_cnt[3:0]] <= ifc.mem_req_addr;
      req_addr_q            <= ifc.mem_req_addr;
      req_cnt               <= req_cnt + 1;
    end
  end

  assign ifc.mem_req_ready  = 1'b1;
  assign ifc.mem_rsp_valid  = 1'b1;
  assign ifc.mem_rsp_data   = {16'hD000, req_addr_q[15:0]};
  assign ifc.mem_rsp_poison = ((req_cnt - 1) == inj_idx);
  assign ifc.mem_rsp_err    = ((req_cnt - 1) == inj_idx);
  assign ifc.mem_rsp_tag    = ((req_cnt - 1) == inj_idx) ? 4'hA : 4'h5;

  // Collected R beats
  int          got_n;
  int          cycles;
  logic [31:0] got_data [16];
  logic [7:0]  got_id   [16];
  logic [31:0] resp_bits, last_bits, poison_bits, trace_bits;
  logic [3:0]  got_tag  [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    @(posedge aclk); #1;
    log_clr = 1'b0;
  endtask

  task automatic issue_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic trace);
    int wait_c;
    ifc.s_axi_arid    = id;
    ifc.s_axi_araddr  = addr;
    ifc.s_axi_arlen   = len;
    ifc.s_axi_arsize  = size;
    ifc.s_axi_arburst = burst;
    ifc.s_axi_artrace = trace;
    ifc.s_axi_arvalid = 1'b1;
    wait_c = 0;
    while (!ifc.s_axi_arready && wait_c < 50) begin
      @(posedge aclk); #1;
      wait_c++;
    end
    if (wait_c >= 50) check("ar_timeout", 1, 0);
    @(posedge aclk); #1;
    ifc.s_axi_arvalid = 1'b0;
  endtask

  task automatic collect(input int n);
    ifc.s_axi_rready = 1'b1;
    got_n = 0; cycles = 0;
    resp_bits = '0; last_bits = '0; poison_bits = '0; trace_bits = '0;
    while (got_n < n && cycles < 200) begin
      if (ifc.s_axi_rvalid) begin
        got_data[got_n]        = ifc.s_axi_rdata;
        got_id[got_n]          = ifc.s_axi_rid;
        got_tag[got_n]         = ifc.s_axi_rtag;
        resp_bits[2*got_n +: 2] = ifc.s_axi_rresp;
        last_bits[got_n]       = ifc.s_axi_rlast;
        poison_bits[got_n]     = ifc.s_axi_rpoison;
        trace_bits[got_n]      = ifc.s_axi_rtrace;
        got_n++;
      end
      @(posedge aclk); #1;
      cycles++;
    end
    ifc.s_axi_rready = 1'b0;
    check("beat_count", 64'(got_n), 64'(n));
  endtask

  logic        stable;
  logic [31:0] snap_data;
  logic [7:0]  snap_id;
  logic [1:0]  snap_resp;
  logic        snap_last;
  int          wc;

  initial begin
    aresetn = 1'b0;
    log_clr = 1'b1;
    inj_idx = -1;
    ifc.s_axi_arvalid = 1'b0; ifc.s_axi_rready = 1'b0;
    ifc.s_axi_arid = '0; ifc.s_axi_araddr = '0; ifc.s_axi_arlen = '0; ifc.s_axi_arsize = '0;
    ifc.s_axi_arburst = '0; ifc.s_axi_arprot = 3'd2; ifc.s_axi_arlock = 1'b0;
    ifc.s_axi_arcache = '0; ifc.s_axi_arqos = '0; ifc.s_axi_aruser = '0; ifc.s_axi_armpam = '0;
    ifc.s_axi_arunique = 1'b0; ifc.s_axi_archunken = 1'b0; ifc.s_axi_artagop = '0;
    ifc.s_axi_arnsaid = 4'h3; ifc.s_axi_armecid = 16'hBEEF; ifc.s_axi_artrace = 1'b0;

    // Reset state
    @(posedge aclk); @(posedge aclk); #1;
    check("rst_arready", ifc.s_axi_arready, 0);
    check("rst_rvalid", ifc.s_axi_rvalid, 0);
    check("rst_mem_req_valid", ifc.mem_req_valid, 0);
    check("rst_mem_rsp_ready", ifc.mem_rsp_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", ifc.s_axi_rdata, 0);
    aresetn = 1'b1;
    log_clr = 1'b0;
    @(posedge aclk); #1;
    check("post_rst_arready", ifc.s_axi_arready, 1);
    clear_log();

    // INCR 0x100 len 3 size 2
    issue_ar(8'h5A, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
    check("incr_req_valid_t1", ifc.mem_req_valid, 1);
    check("incr_arready_low", ifc.s_axi_arready, 0);
    check("incr_mem_prot", ifc.mem_req_prot, 3'd2);
    check("incr_mem_mecid", ifc.mem_req_mecid, 16'hBEEF);
    collect(4);
    check("incr_cycles", 64'(cycles), 12);
    check("incr_req_cnt", 64'(req_cnt), 4);
    check("incr_addr0", req_log[0], 32'h100);
    check("incr_addr1", req_log[1], 32'h104);
    check("incr_addr2", req_log[2], 32'h108);
    check("incr_addr3", req_log[3], 32'h10C);
    check("incr_data0", got_data[0], 32'hD000_0100);
    check("incr_data3", got_data[3], 32'hD000_010C);
    check("incr_resp", resp_bits, 0);
    check("incr_rlast", last_bits, 32'h8);
    check("incr_rid", got_id[3], 8'h5A);
    check("incr_rtag", got_tag[2], 4'h5);
    check("incr_idle_arready", ifc.s_axi_arready, 1);
    check("incr_idle_busy", busy, 0);
    clear_log();

    // WRAP 0x38 len 3 size 2
    issue_ar(8'h11, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);
    collect(4);
    check("wrap_addr0", req_log[0], 32'h38);
    check("wrap_addr1", req_log[1], 32'h3C);
    check("wrap_addr2", req_log[2], 32'h30);
    check("wrap_addr3", req_log[3], 32'h34);
    check("wrap_data2", got_data[2], 32'hD000_0030);
    clear_log();

    // Decode error
    issue_ar(8'h22, 32'h2000, 8'd1, 3'd2, 2'b01, 1'b0);
    collect(2);
    check("dec_resp", resp_bits, 32'hF);
    check("dec_rdata", got_data[0] | got_data[1], 0);
    check("dec_no_mem_req", 64'(req_cnt), 0);
    check("dec_cycles", 64'(cycles), 2);
    check("dec_rlast", last_bits, 32'h2);
    check("dec_rid", got_id[1], 8'h22);
    clear_log();

    // Oversize transfer
    issue_ar(8'h01, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);
    collect(1);
    check("size_resp", resp_bits, 32'h2);
    check("size_rlast", last_bits, 32'h1);
    // Reserved burst
    issue_ar(8'h02, 32'h10, 8'd1, 3'd2, 2'b11, 1'b0);
    collect(2);
    check("rsvd_resp", resp_bits, 32'hA);
    // WRAP with illegal length
    issue_ar(8'h03, 32'h10, 8'd2, 3'd2, 2'b10, 1'b0);
    collect(3);
    check("wraplen_resp", resp_bits, 32'h2A);
    check("proto_no_mem_req", 64'(req_cnt), 0);
    clear_log();

    // Sideband: poison + error on beat 1, trace echo
    inj_idx = 1;
    issue_ar(8'h33, 32'h200, 8'd2, 3'd2, 2'b01, 1'b1);
    collect(3);
    check("sb_resp", resp_bits, 32'h8);
    check("sb_poison", poison_bits, 32'h2);
    check("sb_trace", trace_bits, 32'h7);
    check("sb_tag1", got_tag[1], 4'hA);
    check("sb_tag0", got_tag[0], 4'h5);
    check("sb_data1", got_data[1], 32'hD000_0204);
    inj_idx = -1;
    clear_log();

    // Backpressure: hold rready low for 5 cycles with rvalid up
    issue_ar(8'h44, 32'h300, 8'd1, 3'd2, 2'b01, 1'b0);
    wc = 0;
    while (!ifc.s_axi_rvalid && wc < 50) begin
      @(posedge aclk); #1;
      wc++;
    end
    check("bp_rvalid_seen", ifc.s_axi_rvalid, 1);
    snap_data = ifc.s_axi_rdata; snap_id = ifc.s_axi_rid;
    snap_resp = ifc.s_axi_rresp; snap_last = ifc.s_axi_rlast;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      if (!ifc.s_axi_rvalid || ifc.s_axi_rdata !== snap_data || ifc.s_axi_rid !== snap_id ||
          ifc.s_axi_rresp !== snap_resp || ifc.s_axi_rlast !== snap_last) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_data0", snap_data, 32'hD000_0300);
    collect(2);
    check("bp_data1", got_data[1], 32'hD000_0304);
    check("bp_rlast", last_bits, 32'h2);
    clear_log();

    // Reset mid-burst
    issue_ar(8'h55, 32'h400, 8'd3, 3'd2, 2'b01, 1'b0);
    wc = 0;
    while (!ifc.s_axi_rvalid && wc < 50) begin
      @(posedge aclk); #1;
      wc++;
    end
    check("mid_rvalid_seen", ifc.s_axi_rvalid, 1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("mid_rst_rvalid", ifc.s_axi_rvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_arready", ifc.s_axi_arready, 0);
    check("mid_rst_req_valid", ifc.mem_req_valid, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("mid_rel_arready", ifc.s_axi_arready, 1);
    check("mid_rel_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
